reg_writeback_queue: RTL

//  Write-side companion of the 16x16 register file: queues results from EX/MEM/MUL-DIV, drains one per cycle onto the RF write port.

---
 rtl/reg_writeback_queue_if.sv | 40 ++++
 rtl/reg_writeback_queue.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue_if.sv
// Writeback-queue port bundle: result push, freeze, issue reservation/RAW query, RF write side.
// The master drives results and reservations; the slave is the queue.
interface reg_writeback_queue_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 4
) ();
   logic                   in_valid;
   logic                   in_ready;
   logic [REG_AW-1:0]      in_dst;
   logic [DATA_W-1:0]      in_data;
   logic                   in_lo_en;
   logic [DATA_W-1:0]      in_hi;
   logic                   in_hi_en;
   logic                   freeze;
   logic                   rsv_valid;
   logic [REG_AW-1:0]      rsv_dst;
   logic                   rsv_hi;
   logic [REG_AW-1:0]      q_r1;
   logic [REG_AW-1:0]      q_r2;
   logic                   stall;
   logic [2**REG_AW-1:0]   busy;
   logic [REG_AW-1:0]      wb_dst;
   logic [DATA_W-1:0]      wb_data;
   logic                   wb_wr;
   logic [DATA_W-1:0]      wb_r15_data;
   logic                   wb_wr_r15;
   logic                   sb_err;

   modport master (
      output in_valid, in_dst, in_data, in_lo_en, in_hi, in_hi_en, freeze,
      output rsv_valid, rsv_dst, rsv_hi, q_r1, q_r2,
      input  in_ready, stall, busy, wb_dst, wb_data, wb_wr, wb_r15_data, wb_wr_r15, sb_err
   );

   modport slave (
      input  in_valid, in_dst, in_data, in_lo_en, in_hi, in_hi_en, freeze,
      input  rsv_valid, rsv_dst, rsv_hi, q_r1, q_r2,
      output in_ready, stall, busy, wb_dst, wb_data, wb_wr, wb_r15_data, wb_wr_r15, sb_err
   );
endinterface

// File: rtl/reg_writeback_queue.sv
// Writeback queue for the 16x16 register file with a RAW pending-destination scoreboard.
// Define WB_BYPASS_EN to let a push into an empty, unfrozen queue reach wb_* at the push edge.
module reg_writeback_queue #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned REG_AW  = 4,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned FIFO_AW = 2
) (
   input logic                 clk,
   input logic                 rst,
   reg_writeback_queue_if.slave bus
);
   localparam int unsigned NREG = 2**REG_AW;
   localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(DEPTH);

   typedef struct packed {
      logic [REG_AW-1:0] dst;
      logic [DATA_W-1:0] data;
      logic              loEn;
      logic [DATA_W-1:0] hi;
      logic              hiEn;
   } entry_t;

   entry_t              mem [DEPTH];
   logic [FIFO_AW-1:0]  headPtr;
   logic [FIFO_AW-1:0]  tailPtr;
   logic [FIFO_AW:0]    count;

   logic [REG_AW-1:0]   wbDst;
   logic [DATA_W-1:0]   wbData;
   logic                wbWr;
   logic [DATA_W-1:0]   wbR15Data;
   logic                wbWrR15;

   logic [1:0]          sbCnt [NREG];
   logic                sbErr;
   logic [NREG-1:0]     busyVec;
   logic [NREG-1:0]     incVec;
   logic [NREG-1:0]     decVec;
   logic [NREG-1:0]     errVec;

   entry_t inEntry;
   entry_t wbSrc;
   logic   push;
   logic   pop;
   logic   bypass;
   logic   enqueue;
   logic   load;

   always_comb begin
      inEntry.dst  = bus.in_dst;
      inEntry.data = bus.in_data;
      inEntry.loEn = bus.in_lo_en;
      inEntry.hi   = bus.in_hi;
      inEntry.hiEn = bus.in_hi_en;
      // in_ready comes from the registered count only, so a full queue refuses even while popping
      push   = bus.in_valid && (count < FULL);
      pop    = (count != '0) && !bus.freeze;
      bypass = 1'b0;
`ifdef WB_BYPASS_EN
      bypass = push && (count == '0) && !bus.freeze;
`endif
      enqueue = push && !bypass;
      load    = bypass || pop;
      wbSrc   = bypass ? inEntry : mem[headPtr];
   end

   always_ff @(posedge clk) begin
      if (!rst && enqueue) begin
         mem[tailPtr] <= inEntry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         headPtr <= '0;
         tailPtr <= '0;
         count   <= '0;
      end else begin
         if (enqueue) begin
            tailPtr <= tailPtr + FIFO_AW'(1);
         end
         if (pop) begin
            headPtr <= headPtr + FIFO_AW'(1);
         end
         if (enqueue && !pop) begin
            count <= count + (FIFO_AW+1)'(1);
         end else if (!enqueue && pop) begin
            count <= count - (FIFO_AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wbDst     <= '0;
         wbData    <= '0;
         wbWr      <= 1'b0;
         wbR15Data <= '0;
         wbWrR15   <= 1'b0;
      end else if (load) begin
         wbDst     <= wbSrc.dst;
         wbData    <= wbSrc.data;
         wbWr      <= wbSrc.loEn;
         wbR15Data <= wbSrc.hi;
         // R15 lives at index 0: a primary write to index 0 takes the port
         wbWrR15   <= wbSrc.hiEn && !(wbSrc.loEn && (wbSrc.dst == '0));
      end else begin
         wbWr    <= 1'b0;
         wbWrR15 <= 1'b0;
      end
   end

   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         incVec[i]  = bus.rsv_valid &&
                      ((bus.rsv_dst == REG_AW'(i)) || (bus.rsv_hi && (i == 0)));
         decVec[i]  = (wbWr && (wbDst == REG_AW'(i))) || (wbWrR15 && (i == 0));
         errVec[i]  = (incVec[i] && !decVec[i] && (sbCnt[i] == 2'd3)) ||
                      (decVec[i] && !incVec[i] && (sbCnt[i] == 2'd0));
         busyVec[i] = (sbCnt[i] != 2'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            sbCnt[i] <= 2'd0;
         end
         sbErr <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (incVec[i] && !decVec[i] && (sbCnt[i] != 2'd3)) begin
               sbCnt[i] <= sbCnt[i] + 2'd1;
            end else if (decVec[i] && !incVec[i] && (sbCnt[i] != 2'd0)) begin
               sbCnt[i] <= sbCnt[i] - 2'd1;
            end
         end
         sbErr <= sbErr | (|errVec);
      end
   end

   assign bus.in_ready    = (count < FULL);
   assign bus.stall       = busyVec[bus.q_r1] | busyVec[bus.q_r2];
   assign bus.busy        = busyVec;
   assign bus.wb_dst      = wbDst;
   assign bus.wb_data     = wbData;
   assign bus.wb_wr       = wbWr;
   assign bus.wb_r15_data = wbR15Data;
   assign bus.wb_wr_r15   = wbWrR15;
   assign bus.sb_err      = sbErr;
endmodule
